// File: rtl/ps2_key_fifo_rx.sv
// ps2_key_fifo_rx: filtered PS/2 receiver with prefix handling, key map and event FIFO.
// Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_key_fifo_rx #(
   parameter int CLK_DIV       = 4,
   parameter int FILT_LEN      = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int TIMEOUT_TICKS = 2000
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_break,
   output logic [4:0]                    ev_key,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clear_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);
   localparam int FW = $clog2(FILT_LEN);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t          r_state, w_state_n;
   logic [DW-1:0]   r_div;
   logic [1:0]      r_s0, r_s1, r_filt;
   logic [FW-1:0]   r_fcnt [2];
   logic            r_clk_q, r_byte_v, r_ext, r_brk;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic [TW-1:0]   r_to;
   logic [14:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic            w_tick, w_fall, w_timeout, w_err, w_good, w_push, w_pop, w_full, w_wen;
   logic [AW-1:0]   w_rd_n;
   logic [AW:0]     w_cnt_n;
   logic [14:0]     w_entry, w_head;
   function automatic logic [4:0] f_key(input logic ext, input logic [7:0] c);
      if (ext) return c == 8'h5A ? 5'd16 : 5'd31;
      case (c)
         8'h45: return 5'd0;  8'h16: return 5'd1;  8'h1E: return 5'd2;  8'h26: return 5'd3;
         8'h25: return 5'd4;  8'h2E: return 5'd5;  8'h36: return 5'd6;  8'h3D: return 5'd7;
         8'h3E: return 5'd8;  8'h46: return 5'd9;  8'h1C: return 5'd10; 8'h32: return 5'd11;
         8'h21: return 5'd12; 8'h23: return 5'd13; 8'h24: return 5'd14; 8'h2B: return 5'd15;
         8'h5A: return 5'd16; 8'h66: return 5'd17; 8'h0D: return 5'd18;
         default: return 5'd31;
      endcase
   endfunction
   assign w_tick    = r_div == DW'(CLK_DIV - 1);
   assign w_fall    = r_clk_q & ~r_filt[0];
   assign w_timeout = r_state != IDLE && w_tick && r_to == TW'(TIMEOUT_TICKS - 1);
   always_comb begin
      w_state_n = r_state;
      w_err     = 1'b0;
      w_good    = 1'b0;
      if (w_timeout) begin
         w_state_n = IDLE;
         w_err     = 1'b1;
      end else if (w_fall)
         case (r_state)
            IDLE:   w_state_n = r_filt[1] ? IDLE : DATA;
            DATA:   w_state_n = r_bit == 3'd7 ? PARITY : DATA;
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               w_err     = ~^{r_filt[1], r_shift};
               w_state_n = w_err ? IDLE : STOP;
`else
               w_state_n = STOP;
`endif
            end
            default: begin
               w_state_n = IDLE;
               w_good    = r_filt[1];
               w_err     = ~r_filt[1];
            end
         endcase
   end
   // The completed byte stays in r_shift until the next frame's first data bit.
   assign w_push  = r_byte_v && r_shift != 8'hE0 && r_shift != 8'hF0;
   assign w_pop   = ev_valid & ev_ready;
   assign w_full  = fifo_count == (AW+1)'(FIFO_DEPTH);
   assign w_wen   = w_push & (~w_full | w_pop);
   assign w_rd_n  = r_rd + AW'(w_pop);
   assign w_cnt_n = fifo_count + (AW+1)'(w_wen) - (AW+1)'(w_pop);
   assign w_entry = {r_brk, r_ext, r_shift, f_key(r_ext, r_shift)};
   // Bypass the write when it lands in the slot that becomes the head.
   assign w_head  = (w_wen && r_wr == w_rd_n) ? w_entry : r_mem[w_rd_n];
   always_ff @(posedge clk)
      if (w_wen) r_mem[r_wr] <= w_entry;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_div      <= '0;
         r_s0       <= '1;
         r_s1       <= '1;
         r_filt     <= '1;
         r_fcnt     <= '{default: '0};
         r_clk_q    <= 1'b1;
         r_state    <= IDLE;
         r_bit      <= '0;
         r_shift    <= '0;
         r_to       <= '0;
         r_byte_v   <= 1'b0;
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
         r_wr       <= '0;
         r_rd       <= '0;
         fifo_count <= '0;
         ev_valid   <= 1'b0;
         {ev_break, ev_ext, ev_code, ev_key} <= {10'd0, 5'd31};
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_div   <= w_tick ? '0 : r_div + 1'b1;
         r_s0    <= {ps2_data, ps2_clk};
         r_s1    <= r_s0;
         r_clk_q <= r_filt[0];
         for (int i = 0; i < 2; i++)
            if (w_tick) begin
               if (r_s1[i] == r_filt[i]) r_fcnt[i] <= '0;
               else if (r_fcnt[i] == FW'(FILT_LEN - 1)) begin
                  r_filt[i] <= r_s1[i];
                  r_fcnt[i] <= '0;
               end else r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
         r_state <= w_state_n;
         if (r_state == IDLE) r_bit <= '0;
         else if (w_fall && r_state == DATA) begin
            r_shift <= {r_filt[1], r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
         end
         r_to     <= (r_state == IDLE || w_fall) ? '0 : w_tick ? r_to + 1'b1 : r_to;
         r_byte_v <= w_good;
         if (w_err) {r_ext, r_brk} <= 2'b00;
         else if (r_byte_v) begin
            r_ext <= r_shift == 8'hE0 ? 1'b1 : r_shift == 8'hF0 ? r_ext : 1'b0;
            r_brk <= r_shift == 8'hF0 ? 1'b1 : r_shift == 8'hE0 ? r_brk : 1'b0;
         end
         r_wr       <= r_wr + AW'(w_wen);
         r_rd       <= w_rd_n;
         fifo_count <= w_cnt_n;
         ev_valid   <= w_cnt_n != '0;
         if (w_cnt_n != '0) {ev_break, ev_ext, ev_code, ev_key} <= w_head;
         overflow   <= (w_push & w_full & ~w_pop) ? 1'b1 : clear_err ? 1'b0 : overflow;
         frame_err  <= w_err ? 1'b1 : clear_err ? 1'b0 : frame_err;
      end
   end
endmodule

// File: tb/tb_ps2_key_fifo_rx.sv
// tb_ps2_key_fifo_rx: scoreboard bench for ps2_key_fifo_rx, PS2_PARITY_CHECK_EN aware.
module tb_ps2_key_fifo_rx;
   localparam int CD = 2, FL = 3, FD = 4, TT = 200, H = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif
   localparam logic [7:0] KTBL [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h5A, 8'h66, 8'h0D};
   typedef struct packed {logic brk; logic ext; logic [7:0] code; logic [4:0] key;} ev_t;
   logic       clk = 0, rstn = 0, ps2_clk = 1, ps2_data = 1, ev_ready = 0, clear_err = 0;
   logic       ev_valid, ev_ext, ev_break, overflow, frame_err;
   logic [7:0] ev_code;
   logic [4:0] ev_key;
   logic [2:0] fifo_count;
   int         n_tot = 0, n_bad = 0, cyc = 0, lat = 0;
   logic       pend_e = 0, pend_b = 0;
   ev_t        exp_q[$];
   ev_t        m_e;

   ps2_key_fifo_rx #(.CLK_DIV(CD), .FILT_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_TICKS(TT)) dut (
      .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
      .ev_break(ev_break), .ev_key(ev_key), .fifo_count(fifo_count),
      .overflow(overflow), .frame_err(frame_err), .clear_err(clear_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] ref_key(input logic ext, input logic [7:0] c);
      if (ext) return (c == 8'h5A) ? 5'd16 : 5'd31;
      for (int i = 0; i < 19; i++) if (KTBL[i] == c) return 5'(i);
      return 5'd31;
   endfunction

   task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int nbits = 11, input logic bad = 0,
                       input int pop_at = 0, input logic meas = 0);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad, b, 1'b0};
      while (cyc % CD != 0) tk(1);
      if (nbits < 11 || (bad && PCHK)) {pend_e, pend_b} = 2'b00;
      else if (b == 8'hE0) pend_e = 1'b1;
      else if (b == 8'hF0) pend_b = 1'b1;
      else begin
         exp_q.push_back('{pend_b, pend_e, b, ref_key(pend_e, b)});
         {pend_e, pend_b} = 2'b00;
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         tk(H);
         ps2_clk = 1'b0;
         if (i == 10 && pop_at > 0) begin
            tk(pop_at - 1);
            ev_ready = 1'b1;
            tk(1);
            ev_ready = 1'b0;
            tk(H - pop_at);
         end else if (i == 10 && meas) begin
            for (int k = 1; k <= H; k++) begin
               tk(1);
               if (lat == 0 && ev_valid) lat = k;
            end
         end else tk(H);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tk(2 * H);
   endtask

   task automatic drain();
      ev_ready = 1'b1;
      for (int k = 0; k < 2000 && exp_q.size() > 0; k++) tk(1);
      chk("drain_left", 32'(exp_q.size()), 0);
   endtask

   task automatic clr();
      clear_err = 1'b1;
      tk(1);
      clear_err = 1'b0;
      chk("clr_ferr", 32'(frame_err), 0);
      chk("clr_ovf", 32'(overflow), 0);
   endtask

   task automatic check_reset(input string t);
      chk({t, "_valid"}, 32'(ev_valid), 0);
      chk({t, "_code"}, 32'(ev_code), 0);
      chk({t, "_ext"}, 32'(ev_ext), 0);
      chk({t, "_brk"}, 32'(ev_break), 0);
      chk({t, "_key"}, 32'(ev_key), 31);
      chk({t, "_cnt"}, 32'(fifo_count), 0);
      chk({t, "_ovf"}, 32'(overflow), 0);
      chk({t, "_ferr"}, 32'(frame_err), 0);
   endtask

   always @(negedge clk)
      if (rstn && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) chk("extra_ev", 1, 0);
         else begin
            m_e = exp_q.pop_front();
            chk("ev_code", 32'(ev_code), 32'(m_e.code));
            chk("ev_ext", 32'(ev_ext), 32'(m_e.ext));
            chk("ev_brk", 32'(ev_break), 32'(m_e.brk));
            chk("ev_key", 32'(ev_key), 32'(m_e.key));
         end
      end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tk(5);
      check_reset("rst");
      rstn = 1'b1;
      tk(40);
      send(8'h1C, 11, 0, 0, 1);
      chk("latency", 32'(lat >= 2 + FL * CD - CD + 2 && lat <= 2 + FL * CD + CD + 2), 1);
      chk("mk_valid", 32'(ev_valid), 1);
      chk("mk_code", 32'(ev_code), 32'h1C);
      chk("mk_key", 32'(ev_key), 10);
      chk("mk_brk", 32'(ev_break), 0);
      chk("mk_ext", 32'(ev_ext), 0);
      chk("mk_cnt", 32'(fifo_count), 1);
      drain();
      send(8'hF0); send(8'h45); send(8'hE0); send(8'hF0); send(8'h5A);
      drain();
      ev_ready = 1'b0;
      send(8'h16, 11, 1);
      chk("par_err", 32'(frame_err), 32'(PCHK));
      chk("par_cnt", 32'(fifo_count), PCHK ? 0 : 1);
      drain();
      clr();
      send(8'hAA, 5);
      tk(500);
      chk("to_err", 32'(frame_err), 1);
      clr();
      send(8'h66);
      drain();
      ev_ready = 1'b0;
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
      void'(exp_q.pop_back());
      chk("ov_cnt", 32'(fifo_count), 4);
      chk("ov_flag", 32'(overflow), 1);
      chk("ov_head", 32'(ev_code), 32'h16);
      send(8'h36, 11, 0, lat);
      chk("ov_cnt2", 32'(fifo_count), 4);
      chk("ov_head2", 32'(ev_code), 32'h1E);
      drain();
      clr();
      ev_ready = 1'b0;
      send(8'h3D);
      chk("pre_rst_cnt", 32'(fifo_count), 1);
      send(8'h46, 4);
      rstn = 1'b0;
      ps2_data = 1'b1;
      tk(3);
      check_reset("mid");
      exp_q.delete();
      {pend_e, pend_b} = 2'b00;
      rstn = 1'b1;
      tk(40);
      ev_ready = 1'b1;
      send(8'h46);
      drain();
      chk("post_ferr", 32'(frame_err), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
